add_sub_accumulator: RTL and testbench

Parametrised burst accumulator that applies a stream of add, subtract or load operations to a registered running value and reports carry and signed overflow. A burst is armed by a start pulse and accepts exactly `BURST` valid samples. It then raises a one-cycle done pulse and holds the final value until the next start. The block is the generalised successor of the fixed 8-bit self-accumulating adder/subtractor. It sits between a sample source and a downstream consumer that reads `o_sum` on `o_done`.

---
 rtl/add_sub_accumulator.sv | 129 ++++++++++++
 tb/tb_add_sub_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_accumulator.sv
// Burst add/sub/load accumulator with carry and sticky signed-overflow reporting.
// Optional macro ADD_SUB_ACC_SAT_EN: saturate o_sum on signed overflow instead of wrapping.
module add_sub_accumulator #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNT_W = $clog2(BURST + 1)
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH:0]   w_res;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf_now;
    logic             w_accept;
    logic             w_arm;

    assign w_arm    = (r_state == S_IDLE) && i_start;
    assign w_accept = (r_state == S_RUN) && i_valid;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_RUN;
            S_RUN:   if (w_accept && (r_count == LAST_IDX)) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_res     = {1'b0, r_sum};
        w_sum     = r_sum;
        w_carry   = r_carry;
        w_ovf_now = 1'b0;
        case (op_t'(i_op))
            OP_ADD: begin
                w_res     = {1'b0, r_sum} + {1'b0, i_a};
                w_sum     = w_res[WIDTH-1:0];
                w_carry   = w_res[WIDTH];
                w_ovf_now = (r_sum[WIDTH-1] == i_a[WIDTH-1]) && (w_res[WIDTH-1] != r_sum[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry out of sum + ~a + 1 is the no-borrow flag.
                w_res     = {1'b0, r_sum} + {1'b0, ~i_a} + (WIDTH+1)'(1);
                w_sum     = w_res[WIDTH-1:0];
                w_carry   = w_res[WIDTH];
                w_ovf_now = (r_sum[WIDTH-1] != i_a[WIDTH-1]) && (w_res[WIDTH-1] != r_sum[WIDTH-1]);
            end
            OP_LOAD: begin
                w_sum   = i_a;
                w_carry = 1'b0;
            end
            default: ;
        endcase
`ifdef ADD_SUB_ACC_SAT_EN
        // Overflow direction follows the sign of the running value before the operation.
        if (w_ovf_now) begin
            w_sum = r_sum[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_arm) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else if (w_accept) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
                r_ovf   <= r_ovf | w_ovf_now;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_busy  = (r_state == S_RUN);
    assign o_done  = (r_state == S_DONE);
    assign o_sum   = r_sum;
    assign o_carry = r_carry;
    assign o_ovf   = r_ovf;
    assign o_count = r_count;

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed bench for add_sub_accumulator (WIDTH=8, BURST=4); expectations are hand-computed.
module tb_add_sub_accumulator;

    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int CNT_W = $clog2(BURST + 1);

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] NOP  = 2'b11;

    logic             i_clk = 1'b0;
    logic             ni_rst = 1'b0;
    logic             i_start = 1'b0;
    logic             i_valid = 1'b0;
    logic [1:0]       i_op = NOP;
    logic [WIDTH-1:0] i_a = '0;
    logic             o_busy;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_ovf;
    logic             o_done;
    logic [CNT_W-1:0] o_count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_ref;

    add_sub_accumulator #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_start (i_start),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_a     (i_a),
        .o_busy  (o_busy),
        .o_sum   (o_sum),
        .o_carry (o_carry),
        .o_ovf   (o_ovf),
        .o_done  (o_done),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    // Counts o_done pulses, sampled on the inactive edge.
    always @(negedge i_clk) if (o_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one cycle of inputs, clock it, then return the inputs to idle.
    task automatic cyc(input logic start, input logic valid, input logic [1:0] op, input logic [WIDTH-1:0] a);
        i_start = start;
        i_valid = valid;
        i_op    = op;
        i_a     = a;
        tick();
        i_start = 1'b0;
        i_valid = 1'b0;
        i_op    = NOP;
        i_a     = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_sum", o_sum, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_flags", {o_carry, o_ovf}, 0);
        check("rst_count", o_count, 0);
        ni_rst = 1'b1;

        // 1. Asynchronous reset mid-burst
        cyc(1, 0, NOP, 0);
        check("t1_busy", o_busy, 1);
        cyc(0, 1, ADD, 8'h01);
        cyc(0, 1, ADD, 8'h02);
        check("t1_sum_pre", o_sum, 8'h03);
        check("t1_count_pre", o_count, 2);
        done_ref = done_cnt;
        #2 ni_rst = 1'b0;
        #1;
        check("t1_sum_async", o_sum, 0);
        check("t1_count_async", o_count, 0);
        check("t1_busy_async", o_busy, 0);
        repeat (2) tick();
        ni_rst = 1'b1;
        cyc(0, 1, ADD, 8'h05);
        check("t1_idle_ignores_valid", {o_busy, o_sum}, 0);
        check("t1_no_done", done_cnt, done_ref);

        // 2. Add burst
        cyc(1, 0, NOP, 0);
        cyc(0, 1, ADD, 8'h01);
        cyc(0, 1, ADD, 8'h02);
        cyc(0, 1, ADD, 8'h03);
        check("t2_busy_before_last", o_busy, 1);
        cyc(0, 1, ADD, 8'h04);
        check("t2_sum", o_sum, 8'h0A);
        check("t2_carry_ovf", {o_carry, o_ovf}, 0);
        check("t2_count", o_count, 4);
        check("t2_done", o_done, 1);
        check("t2_busy_in_done", o_busy, 0);
        cyc(0, 0, NOP, 0);
        check("t2_done_one_cycle", o_done, 0);
        check("t2_sum_hold", o_sum, 8'h0A);

        // 3. Borrow and carry
        cyc(1, 0, NOP, 0);
        check("t3_cleared", {o_sum, o_count}, 0);
        cyc(0, 1, LOAD, 8'h05);
        check("t3_load", o_sum, 8'h05);
        cyc(0, 1, SUB, 8'h07);
        check("t3_sub_sum", o_sum, 8'hFE);
        check("t3_sub_carry", o_carry, 0);
        cyc(0, 1, ADD, 8'h02);
        check("t3_add_sum", o_sum, 8'h00);
        check("t3_add_carry", o_carry, 1);
        cyc(0, 1, NOP, 8'hAA);
        check("t3_nop_sum", o_sum, 8'h00);
        check("t3_count", o_count, 4);
        check("t3_done", o_done, 1);
        check("t3_ovf", o_ovf, 0);
        cyc(0, 0, NOP, 0);

        // 4. Signed overflow
        cyc(1, 0, NOP, 0);
        cyc(0, 1, LOAD, 8'h70);
        cyc(0, 1, ADD, 8'h20);
`ifdef ADD_SUB_ACC_SAT_EN
        check("t4_add_sum", o_sum, 8'h7F);
`else
        check("t4_add_sum", o_sum, 8'h90);
`endif
        check("t4_add_ovf", o_ovf, 1);
        check("t4_add_carry", o_carry, 0);
        cyc(0, 1, SUB, 8'h01);
`ifdef ADD_SUB_ACC_SAT_EN
        check("t4_sub_sum", o_sum, 8'h7E);
`else
        check("t4_sub_sum", o_sum, 8'h8F);
`endif
        check("t4_sub_ovf_sticky", o_ovf, 1);
        check("t4_sub_carry", o_carry, 1);
        cyc(0, 1, NOP, 0);
        check("t4_done", o_done, 1);

        // 6. Back-to-back: start in the IDLE cycle right after DONE
        cyc(0, 0, NOP, 0);
        check("t6_idle_holds_ovf", o_ovf, 1);
        cyc(1, 0, NOP, 0);
        check("t6_flags_cleared", {o_ovf, o_carry}, 0);
        check("t6_sum_cleared", o_sum, 0);
        check("t6_busy", o_busy, 1);
        cyc(0, 1, ADD, 8'h05);
        check("t6_first_add", o_sum, 8'h05);
        check("t6_ovf", o_ovf, 0);
        check("t6_count", o_count, 1);
        repeat (3) cyc(0, 1, NOP, 0);
        check("t6_done", o_done, 1);
        cyc(0, 0, NOP, 0);

        // 5. Gaps in i_valid with ignored starts
        done_ref = done_cnt;
        cyc(1, 0, NOP, 0);
        cyc(0, 1, ADD, 8'h01);
        cyc(1, 0, ADD, 8'h01);
        cyc(1, 0, ADD, 8'h01);
        check("t5_gap_hold", {o_sum, 5'(o_count)}, {8'h01, 5'd1});
        cyc(0, 1, ADD, 8'h01);
        cyc(0, 1, ADD, 8'h01);
        cyc(1, 0, ADD, 8'h01);
        check("t5_gap_count", o_count, 3);
        check("t5_gap_busy", o_busy, 1);
        cyc(0, 1, ADD, 8'h01);
        check("t5_sum", o_sum, 8'h04);
        check("t5_done", o_done, 1);
        cyc(1, 0, NOP, 0);
        check("t5_start_in_done_ignored", o_busy, 0);
        cyc(0, 0, NOP, 0);
        check("t5_still_idle", o_busy, 0);
        check("t5_sum_hold", o_sum, 8'h04);
        check("t5_count_hold", o_count, 4);
        check("t5_single_done", done_cnt - done_ref, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
